// File: rtl/mini_rv32i_pkg.sv
// Shared definitions for the mini_rv32i demo core: RV32I encodings, memory
// map, internal select enums and the built-in ROM programs. The optional
// cycle counter is enabled by defining MINI_RV32I_CYCLE_CNT_EN.
package mini_rv32i_pkg;

  // Default geometry and memory map
  localparam int unsigned ROM_WORDS_DEF = 64;
  localparam int unsigned RAM_WORDS_DEF = 64;
  localparam logic [31:0] MMIO_BASE_DEF = 32'h1000_0000;
  localparam logic [31:0] RAM_BASE      = 32'h0000_1000;

  // MMIO register offsets from the MMIO base
  localparam logic [31:0] MMIO_OFF_IN_A  = 32'h0000_0000;
  localparam logic [31:0] MMIO_OFF_IN_B  = 32'h0000_0004;
  localparam logic [31:0] MMIO_OFF_OP    = 32'h0000_0008;
  localparam logic [31:0] MMIO_OFF_RES   = 32'h0000_000C;
  localparam logic [31:0] MMIO_OFF_CYCLE = 32'h0000_0010;

  // Major opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // funct3 values
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b000;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // funct7 values
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL
  } alu_op_e;

  typedef enum logic [2:0] {
    WB_ALU, WB_LUI, WB_AUIPC, WB_PC4, WB_LOAD
  } wb_sel_e;

  typedef enum logic [1:0] {
    PC_SEQ, PC_JAL, PC_JALR, PC_BRANCH
  } pc_sel_e;

  localparam int unsigned PROG_WORDS = 32;
  typedef logic [PROG_WORDS-1:0][31:0] prog_t;

  // Instruction encoders used to build the ROM images
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OPC_OP};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rd, opc};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
  endfunction

  // Calculator program: x5 = MMIO base, x1/x2 operands, x4 op, x3 result
  function automatic prog_t build_default_prog();
    prog_t p;
    p = '0;
    p[0]  = enc_u(20'h10000, 5'd5, OPC_LUI);
    p[1]  = enc_i(12'h000, 5'd5, F3_LW, 5'd1, OPC_LOAD);
    p[2]  = enc_i(12'h004, 5'd5, F3_LW, 5'd2, OPC_LOAD);
    p[3]  = enc_i(12'h008, 5'd5, F3_LW, 5'd4, OPC_LOAD);
    p[4]  = enc_b(13'd28, 5'd0, 5'd4, F3_BEQ);             // op0 -> add
    p[5]  = enc_i(12'd1, 5'd0, F3_ADD, 5'd6, OPC_OP_IMM);
    p[6]  = enc_b(13'd28, 5'd6, 5'd4, F3_BEQ);             // op1 -> sub
    p[7]  = enc_i(12'd2, 5'd0, F3_ADD, 5'd6, OPC_OP_IMM);
    p[8]  = enc_b(13'd28, 5'd6, 5'd4, F3_BEQ);             // op2 -> and
    p[9]  = enc_r(F7_BASE, 5'd2, 5'd1, F3_OR, 5'd3);       // op3: or
    p[10] = enc_j(21'd24, 5'd0);
    p[11] = enc_r(F7_BASE, 5'd2, 5'd1, F3_ADD, 5'd3);      // add
    p[12] = enc_j(21'd16, 5'd0);
    p[13] = enc_r(F7_ALT, 5'd2, 5'd1, F3_ADD, 5'd3);       // sub
    p[14] = enc_j(21'd8, 5'd0);
    p[15] = enc_r(F7_BASE, 5'd2, 5'd1, F3_AND, 5'd3);      // and
    p[16] = enc_s(12'h00C, 5'd3, 5'd5, F3_SW);             // store result
    p[17] = INSTR_EBREAK;
    return p;
  endfunction

  // Cycle-counter probe: two counter reads three instructions apart, x3 = delta
  function automatic prog_t build_cycle_prog();
    prog_t p;
    p = '0;
    p[0] = enc_u(20'h10000, 5'd5, OPC_LUI);
    p[1] = enc_i(12'h010, 5'd5, F3_LW, 5'd1, OPC_LOAD);
    p[2] = INSTR_NOP;
    p[3] = INSTR_NOP;
    p[4] = enc_i(12'h010, 5'd5, F3_LW, 5'd2, OPC_LOAD);
    p[5] = enc_r(F7_ALT, 5'd1, 5'd2, F3_ADD, 5'd3);
    p[6] = enc_s(12'h00C, 5'd3, 5'd5, F3_SW);
    p[7] = INSTR_EBREAK;
    return p;
  endfunction

  localparam prog_t DEFAULT_PROG = build_default_prog();
  localparam prog_t CYCLE_PROG   = build_cycle_prog();

endpackage

// File: rtl/mini_rv32i_alu.sv
// Combinational ALU for mini_rv32i: result plus equal / signed-less-than flags.
module mini_rv32i_alu
  import mini_rv32i_pkg::*;
(
  input  alu_op_e     op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] res_o,
  output logic        eq_o,
  output logic        lt_o
);

  // Operation select; all arithmetic wraps at 32 bits
  always_comb begin
    res_o = 32'h0000_0000;
    case (op_i)
      ALU_ADD: res_o = a_i + b_i;
      ALU_SUB: res_o = a_i - b_i;
      ALU_AND: res_o = a_i & b_i;
      ALU_OR:  res_o = a_i | b_i;
      ALU_XOR: res_o = a_i ^ b_i;
      ALU_SLT: res_o = {31'd0, ($signed(a_i) < $signed(b_i))};
      ALU_SLL: res_o = a_i << b_i[4:0];
      ALU_SRL: res_o = a_i >> b_i[4:0];
      default: res_o = 32'h0000_0000;
    endcase
  end

  assign eq_o = (a_i == b_i);
  assign lt_o = ($signed(a_i) < $signed(b_i));

endmodule

// File: rtl/mini_rv32i.sv
// mini_rv32i: single-cycle RV32I-subset core with built-in ROM, data RAM and
// MMIO calculator ports. Define MINI_RV32I_CYCLE_CNT_EN to add a cycle
// counter readable at MMIO base + 0x10 (reads 0 otherwise).
// PROG_SEL picks the ROM image: 0 = calculator program, 1 = counter probe.
module mini_rv32i
  import mini_rv32i_pkg::*;
#(
  parameter int unsigned ROM_WORDS = ROM_WORDS_DEF,
  parameter int unsigned RAM_WORDS = RAM_WORDS_DEF,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF,
  parameter int unsigned PROG_SEL  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] io_in_a,
  input  logic [31:0] io_in_b,
  input  logic [1:0]  io_op,
  output logic [31:0] io_out_res,
  output logic        io_out_valid,
  output logic [31:0] x3_out,
  output logic        done
);

  localparam int unsigned ROM_AW    = $clog2(ROM_WORDS);
  localparam int unsigned RAM_AW    = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
  localparam prog_t       PROG      = (PROG_SEL == 0) ? DEFAULT_PROG : CYCLE_PROG;

  // Architectural state
  logic [31:0] pc_q;
  logic [31:0] rf_q [32];
  logic [31:0] out_res_q;
  logic        out_valid_q;
  logic        done_q;
  logic [31:0] ram_q [RAM_WORDS];

  // Fetch and field extraction
  logic [31:0] rom_s [ROM_WORDS];
  logic [31:0] instr_s;
  logic [6:0]  opc_s, f7_s;
  logic [4:0]  rd_s, rs1_s, rs2_s;
  logic [2:0]  f3_s;
  logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
  logic [31:0] rs1_val_s, rs2_val_s, pc_plus4_s;

  // Control and datapath
  alu_op_e     alu_op_s;
  logic [31:0] alu_b_s, alu_res_s;
  logic        alu_eq_s, alu_lt_s;
  wb_sel_e     wb_sel_s;
  pc_sel_e     pc_sel_s;
  logic        rf_we_s, mem_we_s, halt_s, br_take_s;
  logic [31:0] rd_wdata_s, pc_next_s, load_data_s;
  logic [31:0] ram_off_s, mmio_off_s;
  logic [29:0] mmio_word_s;
  logic [RAM_AW-1:0] ram_idx_s;
  logic        ram_hit_s, ram_we_s, res_we_s;
  logic        unused_s;

  for (genvar gi = 0; gi < ROM_WORDS; gi++) begin : g_rom
    if (gi < PROG_WORDS) begin : g_prog
      assign rom_s[gi] = PROG[gi];
    end else begin : g_fill
      assign rom_s[gi] = 32'h0000_0000;
    end
  end

  assign instr_s    = rom_s[pc_q[ROM_AW+1:2]];
  assign opc_s      = instr_s[6:0];
  assign rd_s       = instr_s[11:7];
  assign f3_s       = instr_s[14:12];
  assign rs1_s      = instr_s[19:15];
  assign rs2_s      = instr_s[24:20];
  assign f7_s       = instr_s[31:25];
  assign imm_i_s    = {{20{instr_s[31]}}, instr_s[31:20]};
  assign imm_s_s    = {{20{instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
  assign imm_b_s    = {{19{instr_s[31]}}, instr_s[31], instr_s[7], instr_s[30:25],
                       instr_s[11:8], 1'b0};
  assign imm_u_s    = {instr_s[31:12], 12'h000};
  assign imm_j_s    = {{11{instr_s[31]}}, instr_s[31], instr_s[19:12], instr_s[20],
                       instr_s[30:21], 1'b0};
  assign rs1_val_s  = (rs1_s == 5'd0) ? 32'h0000_0000 : rf_q[rs1_s];
  assign rs2_val_s  = (rs2_s == 5'd0) ? 32'h0000_0000 : rf_q[rs2_s];
  assign pc_plus4_s = pc_q + 32'd4;

  mini_rv32i_alu u_alu (
    .op_i  (alu_op_s),
    .a_i   (rs1_val_s),
    .b_i   (alu_b_s),
    .res_o (alu_res_s),
    .eq_o  (alu_eq_s),
    .lt_o  (alu_lt_s)
  );

  // Instruction decode: anything not recognised halts the core
  always_comb begin
    alu_op_s = ALU_ADD;
    alu_b_s  = rs2_val_s;
    wb_sel_s = WB_ALU;
    pc_sel_s = PC_SEQ;
    rf_we_s  = 1'b0;
    mem_we_s = 1'b0;
    halt_s   = 1'b0;
    case (opc_s)
      OPC_LUI: begin
        rf_we_s  = 1'b1;
        wb_sel_s = WB_LUI;
      end
      OPC_AUIPC: begin
        rf_we_s  = 1'b1;
        wb_sel_s = WB_AUIPC;
      end
      OPC_JAL: begin
        rf_we_s  = 1'b1;
        wb_sel_s = WB_PC4;
        pc_sel_s = PC_JAL;
      end
      OPC_JALR: begin
        if (f3_s == F3_JALR) begin
          rf_we_s  = 1'b1;
          wb_sel_s = WB_PC4;
          alu_b_s  = imm_i_s;
          pc_sel_s = PC_JALR;
        end else begin
          halt_s = 1'b1;
        end
      end
      OPC_BRANCH: begin
        if ((f3_s == F3_BEQ) || (f3_s == F3_BNE) || (f3_s == F3_BLT) || (f3_s == F3_BGE)) begin
          pc_sel_s = PC_BRANCH;
        end else begin
          halt_s = 1'b1;
        end
      end
      OPC_LOAD: begin
        if (f3_s == F3_LW) begin
          rf_we_s  = 1'b1;
          wb_sel_s = WB_LOAD;
          alu_b_s  = imm_i_s;
        end else begin
          halt_s = 1'b1;
        end
      end
      OPC_STORE: begin
        if (f3_s == F3_SW) begin
          mem_we_s = 1'b1;
          alu_b_s  = imm_s_s;
        end else begin
          halt_s = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        rf_we_s = 1'b1;
        alu_b_s = imm_i_s;
        case (f3_s)
          F3_ADD: alu_op_s = ALU_ADD;
          F3_XOR: alu_op_s = ALU_XOR;
          F3_OR:  alu_op_s = ALU_OR;
          F3_AND: alu_op_s = ALU_AND;
          F3_SLL: begin
            alu_op_s = ALU_SLL;
            halt_s   = (f7_s != F7_BASE);
          end
          F3_SRL: begin
            alu_op_s = ALU_SRL;
            halt_s   = (f7_s != F7_BASE);
          end
          default: halt_s = 1'b1;
        endcase
      end
      OPC_OP: begin
        rf_we_s = 1'b1;
        case ({f7_s, f3_s})
          {F7_BASE, F3_ADD}: alu_op_s = ALU_ADD;
          {F7_ALT,  F3_ADD}: alu_op_s = ALU_SUB;
          {F7_BASE, F3_AND}: alu_op_s = ALU_AND;
          {F7_BASE, F3_OR}:  alu_op_s = ALU_OR;
          {F7_BASE, F3_XOR}: alu_op_s = ALU_XOR;
          {F7_BASE, F3_SLT}: alu_op_s = ALU_SLT;
          default:           halt_s   = 1'b1;
        endcase
      end
      OPC_SYSTEM: halt_s = 1'b1;   // EBREAK (other SYSTEM encodings also stop)
      default:    halt_s = 1'b1;
    endcase
  end

  // Branch condition evaluation from the ALU compare flags
  always_comb begin
    br_take_s = 1'b0;
    case (f3_s)
      F3_BEQ:  br_take_s = alu_eq_s;
      F3_BNE:  br_take_s = !alu_eq_s;
      F3_BLT:  br_take_s = alu_lt_s;
      F3_BGE:  br_take_s = !alu_lt_s;
      default: br_take_s = 1'b0;
    endcase
  end

  // Next-PC selection
  always_comb begin
    pc_next_s = pc_plus4_s;
    case (pc_sel_s)
      PC_JAL:    pc_next_s = pc_q + imm_j_s;
      PC_JALR:   pc_next_s = alu_res_s & 32'hFFFF_FFFE;
      PC_BRANCH: pc_next_s = br_take_s ? (pc_q + imm_b_s) : pc_plus4_s;
      default:   pc_next_s = pc_plus4_s;
    endcase
  end

  // Address decode; low two address bits are don't-care for word access
  assign ram_off_s   = alu_res_s - RAM_BASE;
  assign ram_hit_s   = (ram_off_s < RAM_BYTES);
  assign ram_idx_s   = ram_off_s[RAM_AW+1:2];
  assign mmio_off_s  = alu_res_s - MMIO_BASE;
  assign mmio_word_s = mmio_off_s[31:2];
  assign ram_we_s    = mem_we_s && ram_hit_s;
  assign res_we_s    = mem_we_s && (mmio_word_s == MMIO_OFF_RES[31:2]);
  assign unused_s    = ^{ram_off_s[1:0], mmio_off_s[1:0]};

`ifdef MINI_RV32I_CYCLE_CNT_EN
  logic [31:0] cycle_cnt_q;

  // Free-running count of non-halted cycles since reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_q <= 32'h0000_0000;
    end else if (!done_q) begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
    end else begin
      cycle_cnt_q <= cycle_cnt_q;
    end
  end
`endif

  // Load data mux: RAM, MMIO inputs, optional counter, else zero
  always_comb begin
    load_data_s = 32'h0000_0000;
    if (ram_hit_s) begin
      load_data_s = ram_q[ram_idx_s];
    end else if (mmio_word_s == MMIO_OFF_IN_A[31:2]) begin
      load_data_s = io_in_a;
    end else if (mmio_word_s == MMIO_OFF_IN_B[31:2]) begin
      load_data_s = io_in_b;
    end else if (mmio_word_s == MMIO_OFF_OP[31:2]) begin
      load_data_s = {30'd0, io_op};
    end else if (mmio_word_s == MMIO_OFF_CYCLE[31:2]) begin
`ifdef MINI_RV32I_CYCLE_CNT_EN
      load_data_s = cycle_cnt_q;
`else
      load_data_s = 32'h0000_0000;
`endif
    end else begin
      load_data_s = 32'h0000_0000;
    end
  end

  // Register write-back value
  always_comb begin
    rd_wdata_s = alu_res_s;
    case (wb_sel_s)
      WB_LUI:   rd_wdata_s = imm_u_s;
      WB_AUIPC: rd_wdata_s = pc_q + imm_u_s;
      WB_PC4:   rd_wdata_s = pc_plus4_s;
      WB_LOAD:  rd_wdata_s = load_data_s;
      default:  rd_wdata_s = alu_res_s;
    endcase
  end

  // Retire one instruction per edge; a halting instruction only sets done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= 32'h0000_0000;
      out_res_q   <= 32'h0000_0000;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= 32'h0000_0000;
      end
    end else if (done_q) begin
      pc_q <= pc_q;
    end else if (halt_s) begin
      done_q <= 1'b1;
    end else begin
      pc_q <= pc_next_s;
      if (rf_we_s && (rd_s != 5'd0)) begin
        rf_q[rd_s] <= rd_wdata_s;
      end
      if (res_we_s) begin
        out_res_q   <= rs2_val_s;
        out_valid_q <= 1'b1;
      end
    end
  end

  // Data RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (!rst && !done_q && !halt_s && ram_we_s) begin
      ram_q[ram_idx_s] <= rs2_val_s;
    end
  end

  assign io_out_res   = out_res_q;
  assign io_out_valid = out_valid_q;
  assign x3_out       = rf_q[3];
  assign done         = done_q;

endmodule

// File: tb/tb_mini_rv32i.sv
// Directed self-checking bench for mini_rv32i. A second instance runs the
// cycle-counter probe ROM image (PROG_SEL=1).
module tb_mini_rv32i;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] io_in_a = 32'd0;
  logic [31:0] io_in_b = 32'd0;
  logic [1:0]  io_op = 2'd0;
  logic [31:0] io_out_res, x3_out, cc_res, cc_x3;
  logic        io_out_valid, done, cc_valid, cc_done;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  mini_rv32i u_dut (
    .clk(clk), .rst(rst), .io_in_a(io_in_a), .io_in_b(io_in_b), .io_op(io_op),
    .io_out_res(io_out_res), .io_out_valid(io_out_valid), .x3_out(x3_out), .done(done)
  );

  mini_rv32i #(.PROG_SEL(1)) u_dut_cc (
    .clk(clk), .rst(rst), .io_in_a(io_in_a), .io_in_b(io_in_b), .io_op(io_op),
    .io_out_res(cc_res), .io_out_valid(cc_valid), .x3_out(cc_x3), .done(cc_done)
  );

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
  endtask

  // Returns number of edges until done, or -1 if not within 20 cycles
  task automatic wait_done(output int edges);
    edges = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        edges = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (x3_out !== 32'd0) begin bad++; $display("FAIL reset_x3: got %h expected %h", x3_out, 32'd0); end
    total++; if (io_out_res !== 32'd0) begin bad++; $display("FAIL reset_res: got %h expected %h", io_out_res, 32'd0); end
    total++; if (io_out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", io_out_valid); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", done); end
  endtask

  task automatic test_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic [31:0] exp);
    int edges;
    io_in_a = a;
    io_in_b = b;
    io_op   = op;
    apply_reset();
    wait_done(edges);
    total++; if (edges < 0) begin bad++; $display("FAIL %s_timeout: got no done expected done within 20 cycles", name); end
    total++; if (x3_out !== exp) begin bad++; $display("FAIL %s_x3: got %h expected %h", name, x3_out, exp); end
    total++; if (io_out_res !== exp) begin bad++; $display("FAIL %s_res: got %h expected %h", name, io_out_res, exp); end
    total++; if (io_out_valid !== 1'b1) begin bad++; $display("FAIL %s_valid: got %b expected 1", name, io_out_valid); end
  endtask

  // op0 path retires 9 instructions: SW is the 8th, EBREAK the 9th
  task automatic test_progress();
    io_in_a = 32'd21;
    io_in_b = 32'd9;
    io_op   = 2'd0;
    apply_reset();
    repeat (3) @(negedge clk);
    total++; if (io_out_valid !== 1'b0) begin bad++; $display("FAIL prog_valid_early: got %b expected 0", io_out_valid); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL prog_done_early: got %b expected 0", done); end
    repeat (4) @(negedge clk);
    total++; if (io_out_valid !== 1'b0) begin bad++; $display("FAIL prog_valid_pre_sw: got %b expected 0", io_out_valid); end
    @(negedge clk);
    total++; if (io_out_valid !== 1'b1) begin bad++; $display("FAIL prog_valid_at_sw: got %b expected 1", io_out_valid); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL prog_done_at_sw: got %b expected 0", done); end
    total++; if (io_out_res !== 32'd30) begin bad++; $display("FAIL prog_res_at_sw: got %h expected %h", io_out_res, 32'd30); end
    @(negedge clk);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL prog_done_at_ebreak: got %b expected 1", done); end
  endtask

  task automatic test_freeze();
    io_in_a = 32'hDEAD_BEEF;
    io_in_b = 32'h0000_0077;
    io_op   = 2'd3;
    repeat (100) @(negedge clk);
    total++; if (x3_out !== 32'd30) begin bad++; $display("FAIL freeze_x3: got %h expected %h", x3_out, 32'd30); end
    total++; if (io_out_res !== 32'd30) begin bad++; $display("FAIL freeze_res: got %h expected %h", io_out_res, 32'd30); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL freeze_done: got %b expected 1", done); end
  endtask

  task automatic test_mid_reset();
    int edges;
    io_in_a = 32'd21;
    io_in_b = 32'd9;
    io_op   = 2'd1;
    apply_reset();
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if ({done, io_out_valid, x3_out, io_out_res} !== 66'd0) begin bad++; $display("FAIL midrst_outputs: got %b/%b/%h/%h expected all zero", done, io_out_valid, x3_out, io_out_res); end
    @(negedge clk);
    rst = 1'b0;
    wait_done(edges);
    total++; if (edges < 0) begin bad++; $display("FAIL midrst_rerun_timeout: got no done expected done within 20 cycles"); end
    total++; if (io_out_res !== 32'd12) begin bad++; $display("FAIL midrst_rerun_res: got %h expected %h", io_out_res, 32'd12); end
    // Reset arriving between edges after completion must clear everything at once
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (x3_out !== 32'd0) begin bad++; $display("FAIL async_rst_x3: got %h expected %h", x3_out, 32'd0); end
    total++; if (io_out_res !== 32'd0) begin bad++; $display("FAIL async_rst_res: got %h expected %h", io_out_res, 32'd0); end
    total++; if ({done, io_out_valid} !== 2'b00) begin bad++; $display("FAIL async_rst_flags: got %b expected 00", {done, io_out_valid}); end
    @(negedge clk);
    rst = 1'b0;
    wait_done(edges);
    total++; if (x3_out !== 32'd12) begin bad++; $display("FAIL async_rst_rerun_x3: got %h expected %h", x3_out, 32'd12); end
  endtask

  task automatic test_cycle_cnt();
    logic [31:0] exp_cc;
    int          edges;
`ifdef MINI_RV32I_CYCLE_CNT_EN
    exp_cc = 32'd3;
`else
    exp_cc = 32'd0;
`endif
    apply_reset();
    edges = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (cc_done === 1'b1) begin
        edges = k;
        break;
      end
    end
    total++; if (edges < 0) begin bad++; $display("FAIL cc_timeout: got no done expected done within 20 cycles"); end
    total++; if (cc_x3 !== exp_cc) begin bad++; $display("FAIL cc_delta_x3: got %h expected %h", cc_x3, exp_cc); end
    total++; if (cc_res !== exp_cc) begin bad++; $display("FAIL cc_delta_res: got %h expected %h", cc_res, exp_cc); end
    total++; if (cc_valid !== 1'b1) begin bad++; $display("FAIL cc_valid: got %b expected 1", cc_valid); end
  endtask

  initial begin
    test_reset();
    test_op("add",      32'd21, 32'd9,  2'd0, 32'd30);
    test_op("sub",      32'd21, 32'd9,  2'd1, 32'd12);
    test_op("sub_wrap", 32'd9,  32'd21, 2'd1, 32'hFFFF_FFF4);
    test_op("and",      32'd21, 32'd9,  2'd2, 32'd1);
    test_op("or",       32'd21, 32'd9,  2'd3, 32'd29);
    test_progress();
    test_freeze();
    test_mid_reset();
    test_cycle_cnt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
